// File: rtl/frame_tx_framer.sv
// Transmit framer: prefixes each frame of packed pixel bytes with a two-byte SOF header
// and only loads new output bytes while the host's synchronized CTS is asserted.
module frame_tx_framer #(
    parameter int                 width_p       = 8,
    parameter int                 frame_bytes_p = 9600,
    parameter logic [width_p-1:0] sof0_p        = 8'hA5,
    parameter logic [width_p-1:0] sof1_p        = 8'h5A
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               valid_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               valid_o,
    output logic [width_p-1:0] data_o,
    input  logic               ready_i,
    input  logic               cts_i,
    output logic               frame_done_o
);

    localparam int cnt_w_lp = (frame_bytes_p > 1) ? $clog2(frame_bytes_p) : 1;
    localparam logic [cnt_w_lp-1:0] last_idx_lp = cnt_w_lp'(frame_bytes_p - 1);

    typedef enum logic [1:0] {
        IDLE,
        HDR1,
        PAYLOAD
    } state_e;

    state_e               state_r, state_n;
    logic [cnt_w_lp-1:0]  cnt_r, cnt_n;
    logic                 cts_meta_r, cts_s;
    logic                 last_r, last_n;
    logic                 load;
    logic [width_p-1:0]   load_data;
    logic                 slot_free, load_ok;

    always_comb begin
        slot_free = ~valid_o | ready_i;
        load_ok   = slot_free & cts_s;
        state_n   = state_r;
        cnt_n     = cnt_r;
        load      = 1'b0;
        load_data = data_i;
        last_n    = 1'b0;
        ready_o   = 1'b0;
        case (state_r)
            IDLE: begin
                // Header starts only once the packer has a byte waiting; that byte stays unconsumed.
                if (valid_i && load_ok) begin
                    load      = 1'b1;
                    load_data = sof0_p;
                    state_n   = HDR1;
                end
            end
            HDR1: begin
                if (load_ok) begin
                    load      = 1'b1;
                    load_data = sof1_p;
                    state_n   = PAYLOAD;
                end
            end
            PAYLOAD: begin
                ready_o = load_ok;
                if (valid_i && load_ok) begin
                    load = 1'b1;
                    if (cnt_r == last_idx_lp) begin
                        cnt_n   = '0;
                        last_n  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        cnt_n = cnt_r + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r    <= IDLE;
            cnt_r      <= '0;
            cts_meta_r <= 1'b0;
            cts_s      <= 1'b0;
            valid_o    <= 1'b0;
            data_o     <= '0;
            last_r     <= 1'b0;
        end else begin
            cts_meta_r <= cts_i;
            cts_s      <= cts_meta_r;
            state_r    <= state_n;
            cnt_r      <= cnt_n;
            if (load) begin
                valid_o <= 1'b1;
                data_o  <= load_data;
                last_r  <= last_n;
            end else if (ready_i) begin
                valid_o <= 1'b0;
                last_r  <= 1'b0;
            end
        end
    end

    assign frame_done_o = valid_o & ready_i & last_r;

endmodule

// File: tb/tb_frame_tx_framer.sv
// Scoreboard bench for frame_tx_framer: expected header+payload streams are queued per frame,
// a negedge monitor pops them on every output handshake.
module tb_frame_tx_framer;

    localparam logic [7:0] SOF0 = 8'hA5;
    localparam logic [7:0] SOF1 = 8'h5A;
    localparam int         NB   = 4;

    logic       clk = 1'b0;
    logic       reset_i = 1'b1;
    logic       valid_i = 1'b0;
    logic [7:0] data_i = '0;
    logic       ready_o;
    logic       valid_o;
    logic [7:0] data_o;
    logic       ready_i;
    logic       cts_i = 1'b0;
    logic       frame_done_o;

    logic       rdy_mode = 1'b0;
    logic       rdy_manual = 1'b1;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [7:0] d;
        logic       last;
    } exp_t;
    exp_t exp_q[$];

    logic       hold_v = 1'b0;
    logic [7:0] hold_d = '0;

    frame_tx_framer #(
        .width_p(8),
        .frame_bytes_p(NB),
        .sof0_p(SOF0),
        .sof1_p(SOF1)
    ) dut (
        .clk_i(clk),
        .reset_i(reset_i),
        .valid_i(valid_i),
        .data_i(data_i),
        .ready_o(ready_o),
        .valid_o(valid_o),
        .data_o(data_o),
        .ready_i(ready_i),
        .cts_i(cts_i),
        .frame_done_o(frame_done_o)
    );

    always #20 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // A frame on the wire is SOF0, SOF1, then the payload; only the final payload byte ends it.
    task automatic push_frame(input logic [31:0] pay, input int n, input bit complete);
        exp_q.push_back({SOF0, 1'b0});
        exp_q.push_back({SOF1, 1'b0});
        for (int i = 0; i < n; i++)
            exp_q.push_back({pay[31-8*i -: 8], (complete && i == NB - 1) ? 1'b1 : 1'b0});
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        valid_i = 1'b1;
        data_i  = b;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (ready_o) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("send_timeout", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [31:0] pay);
        for (int i = 0; i < NB; i++) send_byte(pay[31-8*i -: 8]);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 1000; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            ready_i = rdy_mode ? 1'($urandom_range(0, 1)) : rdy_manual;
        end
    end

    always @(negedge clk) begin
        if (reset_i) begin
            exp_q.delete();
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                check("hold_valid", 32'(valid_o), 32'd1);
                check("hold_data", 32'(data_o), 32'(hold_d));
            end
            if (valid_o && ready_i) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", 32'(data_o), 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("data", 32'(data_o), 32'(e.d));
                    check("frame_done", 32'(frame_done_o), 32'(e.last));
                end
            end else begin
                check("frame_done_idle", 32'(frame_done_o), 32'd0);
            end
            hold_v = valid_o && !ready_i;
            hold_d = data_o;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pay;
        int gaps;
        bit seen;

        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_ready", 32'(ready_o), 32'd0);
        check("rst_done", 32'(frame_done_o), 32'd0);
        check("rst_data", 32'(data_o), 32'd0);
        @(posedge clk);
        #1;
        reset_i = 1'b0;

        // CTS held low from reset: nothing may leave; then first frame 11,22,33,44.
        push_frame(32'h11223344, NB, 1'b1);
        valid_i = 1'b1;
        data_i  = 8'h11;
        repeat (4) begin
            @(negedge clk);
            check("cts_low_quiet", {30'd0, valid_o, ready_o}, 32'd0);
        end
        @(posedge clk);
        #1;
        cts_i = 1'b1;
        @(negedge clk); check("cts_lat0", 32'(valid_o), 32'd0);
        @(negedge clk); check("cts_lat1", 32'(valid_o), 32'd0);
        @(negedge clk);
        check("cts_lat2", 32'(valid_o), 32'd0);
        check("hdr_ready0", 32'(ready_o), 32'd0);
        @(negedge clk);
        check("cts_lat3", 32'(valid_o), 32'd1);
        check("cts_first", 32'(data_o), 32'(SOF0));
        check("hdr_ready1", 32'(ready_o), 32'd0);
        send_frame(32'h11223344);
        valid_i = 1'b0;
        drain("drain_first");

        // Back-to-back frames with ready_i held high must stream without a bubble.
        push_frame(32'h01020304, NB, 1'b1);
        push_frame(32'h05060708, NB, 1'b1);
        fork
            begin
                send_frame(32'h01020304);
                send_frame(32'h05060708);
                valid_i = 1'b0;
            end
            begin
                seen = 1'b0;
                gaps = 0;
                for (int i = 0; i < 100 && !seen; i++) begin
                    @(negedge clk);
                    if (valid_o && ready_i) seen = 1'b1;
                end
                check("b2b_start", 32'(seen), 32'd1);
                for (int i = 0; i < 11; i++) begin
                    @(negedge clk);
                    if (!(valid_o && ready_i)) gaps++;
                end
                check("b2b_no_bubble", 32'(gaps), 32'd0);
            end
        join
        drain("drain_b2b");

        // CTS drops while 22 is stalled: 22 held, then nothing more until CTS returns.
        push_frame(32'h11223344, NB, 1'b1);
        send_byte(8'h11);
        send_byte(8'h22);
        valid_i    = 1'b0;
        rdy_manual = 1'b0;
        cts_i      = 1'b0;
        repeat (5) @(negedge clk);
        check("cts_hold_valid", 32'(valid_o), 32'd1);
        check("cts_hold_data", 32'(data_o), 32'h22);
        @(posedge clk);
        #1;
        rdy_manual = 1'b1;
        valid_i    = 1'b1;
        data_i     = 8'h33;
        @(negedge clk);
        check("cts_gate_ready", 32'(ready_o), 32'd0);
        repeat (3) begin
            @(negedge clk);
            check("cts_gate_quiet", {30'd0, valid_o, ready_o}, 32'd0);
        end
        @(posedge clk);
        #1;
        cts_i = 1'b1;
        send_byte(8'h33);
        send_byte(8'h44);
        valid_i = 1'b0;
        drain("drain_cts");

        // Random backpressure and packer gaps across many frames.
        rdy_mode = 1'b1;
        for (int f = 0; f < 12; f++) begin
            pay = $urandom();
            push_frame(pay, NB, 1'b1);
            for (int i = 0; i < NB; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    valid_i = 1'b0;
                    repeat ($urandom_range(1, 3)) begin
                        @(posedge clk);
                        #1;
                    end
                end
                send_byte(pay[31-8*i -: 8]);
            end
        end
        valid_i = 1'b0;
        drain("drain_random");
        rdy_mode   = 1'b0;
        rdy_manual = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Reset after two payload bytes: partial frame abandoned, next frame restarts with header.
        push_frame(32'hC1C2C3C4, 2, 1'b0);
        send_byte(8'hC1);
        send_byte(8'hC2);
        rdy_manual = 1'b0;
        data_i     = 8'hC3;
        @(negedge clk);
        check("pre_rst_hold", {23'd0, valid_o, data_o}, {23'd0, 1'b1, 8'hC2});
        @(posedge clk);
        #1;
        reset_i = 1'b1;
        valid_i = 1'b0;
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", 32'(valid_o), 32'd0);
        check("mid_rst_ready", 32'(ready_o), 32'd0);
        check("mid_rst_done", 32'(frame_done_o), 32'd0);
        check("mid_rst_data", 32'(data_o), 32'd0);
        rdy_manual = 1'b1;
        push_frame(32'hD1D2D3D4, NB, 1'b1);
        @(posedge clk);
        #1;
        send_frame(32'hD1D2D3D4);
        valid_i = 1'b0;
        drain("drain_after_rst");

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
